// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline decode constants and FSM state type
// Purpose: opcode encodings, instruction field positions, the return-address
//          register number and the interlock FSM state enum, shared by the
//          interlock unit and the forwarding units.
// Ports:   none (package).
package pipeline_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int IMM_BIT = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 22;
  localparam int RS1_HI = 21;
  localparam int RS1_LO = 18;
  localparam int RS2_HI = 17;
  localparam int RS2_LO = 14;

  localparam logic [3:0] RA_REG = 4'hF;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
    return ir[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [3:0] ir_rd(input logic [31:0] ir);
    return ir[RD_HI:RD_LO];
  endfunction

endpackage

// File: rtl/load_use_interlock_unit_if.sv
// rtl/load_use_interlock_unit_if.sv - pipeline-side bundle for the load-use interlock
// Purpose: groups the OF/EX instruction words, branch flush and stall controls.
// Ports:   master = pipeline side (drives IRs/branch, receives stall controls);
//          slave  = interlock unit (receives IRs/branch, drives stall controls).
interface load_use_interlock_unit_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      input_OF_IR;
  logic [31:0]      input_EX_IR;
  logic             is_branch_taken;
  logic             stall_pc;
  logic             stall_if_of;
  logic             bubble_ex;
  logic             interlock_active;
  logic [CNT_W-1:0] interlock_count;

  modport master (
    output input_OF_IR, input_EX_IR, is_branch_taken,
    input  stall_pc, stall_if_of, bubble_ex, interlock_active, interlock_count
  );

  modport slave (
    input  input_OF_IR, input_EX_IR, is_branch_taken,
    output stall_pc, stall_if_of, bubble_ex, interlock_active, interlock_count
  );
endinterface

// File: rtl/operand_reads_decoder.sv
// rtl/operand_reads_decoder.sv - which registers an instruction reads as sources
// Purpose: combinational decode of the source registers read by an instruction.
// Ports:   ir        - instruction word
//          src1_used - src1 operand is a register read; src1 - its number
//          src2_used - src2 (or store-data) is a register read; src2 - its number
module operand_reads_decoder
  import pipeline_pkg::*;
(
  input  logic [31:0] ir,
  output logic        src1_used,
  output logic [3:0]  src1,
  output logic        src2_used,
  output logic [3:0]  src2
);

  logic [4:0] op;

  always_comb begin
    op        = ir_opcode(ir);
    src1_used = 1'b1;
    src1      = ir[RS1_HI:RS1_LO];
    src2_used = 1'b0;
    src2      = ir[RS2_HI:RS2_LO];

    case (op)
      OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_NOT, OP_MOV: src1_used = 1'b0;
      OP_RET: src1 = RA_REG;  // return target comes from the link register
      default: ;
    endcase

    // Store data travels in the rd field, so st reads rd as its second source.
    if (op == OP_ST) begin
      src2_used = 1'b1;
      src2      = ir_rd(ir);
    end else if (!ir[IMM_BIT] && (op <= OP_ASR)) begin
      src2_used = 1'b1;
    end
  end

endmodule

// File: rtl/load_use_interlock_unit.sv
// rtl/load_use_interlock_unit.sv - load-use hazard stall and bubble generator
// Purpose: stalls PC and IF/OF and bubbles OF/EX for STALL_CYCLES cycles when
//          the OF instruction reads the destination of an ld in EX; a taken
//          branch cancels any stall. Counts interlock events (saturating).
// Ports:   clk, reset (async, active-high)
//          bus (slave) - OF/EX IRs, branch flush in; stall controls and count out
module load_use_interlock_unit
  import pipeline_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  load_use_interlock_unit_if.slave bus
);

  state_t           state_q, state_d;
  logic [3:0]       remain_q, remain_d;
  logic [CNT_W-1:0] interlock_count_q, interlock_count_d;

  logic       src1_used, src2_used;
  logic [3:0] src1, src2;
  logic [3:0] ex_rd;
  logic       ex_is_ld;
  logic       hazard;
  logic       stall;
  logic       active;

  operand_reads_decoder u_of_reads (
    .ir       (bus.input_OF_IR),
    .src1_used(src1_used),
    .src1     (src1),
    .src2_used(src2_used),
    .src2     (src2)
  );

  always_comb begin
    ex_is_ld = (ir_opcode(bus.input_EX_IR) == OP_LD);
    ex_rd    = ir_rd(bus.input_EX_IR);
    hazard   = ex_is_ld && ((src1_used && (src1 == ex_rd)) ||
                            (src2_used && (src2 == ex_rd)));

    state_d           = state_q;
    remain_d          = remain_q;
    interlock_count_d = interlock_count_q;
    stall             = 1'b0;
    active            = 1'b0;

    if (bus.is_branch_taken) begin
      // Never hold a wrong-path instruction: the flush wins over any stall.
      state_d  = RUN;
      remain_d = 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            stall    = 1'b1;
            remain_d = 4'(STALL_CYCLES - 1);
            if (STALL_CYCLES > 1) state_d = STALL;
            if (interlock_count_q != '1)
              interlock_count_d = interlock_count_q + CNT_W'(1);
          end
        end
        STALL: begin
          // EX holds the bubble here, so a live hazard is not a new event.
          stall    = 1'b1;
          active   = 1'b1;
          remain_d = remain_q - 4'd1;
          if (remain_q == 4'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= RUN;
      remain_q          <= 4'd0;
      interlock_count_q <= '0;
    end else begin
      state_q           <= state_d;
      remain_q          <= remain_d;
      interlock_count_q <= interlock_count_d;
    end
  end

  // Combinational hazard path is masked so nothing stalls while in reset.
  assign bus.stall_pc         = stall && !reset;
  assign bus.stall_if_of      = stall && !reset;
  assign bus.bubble_ex        = stall && !reset;
  assign bus.interlock_active = active && !reset;
  assign bus.interlock_count  = interlock_count_q;

endmodule

// File: tb/tb_load_use_interlock_unit.sv
// tb/tb_load_use_interlock_unit.sv - self-checking bench for load_use_interlock_unit
module tb_load_use_interlock_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] of_ir = '0;
  logic [31:0] ex_ir = '0;
  logic        br_taken = 1'b0;

  always #5 clk = ~clk;

  load_use_interlock_unit_if #(.CNT_W(16)) if_a ();
  load_use_interlock_unit_if #(.CNT_W(16)) if_b ();
  load_use_interlock_unit_if #(.CNT_W(2))  if_c ();

  assign if_a.input_OF_IR = of_ir;  assign if_a.input_EX_IR = ex_ir;  assign if_a.is_branch_taken = br_taken;
  assign if_b.input_OF_IR = of_ir;  assign if_b.input_EX_IR = ex_ir;  assign if_b.is_branch_taken = br_taken;
  assign if_c.input_OF_IR = of_ir;  assign if_c.input_EX_IR = ex_ir;  assign if_c.is_branch_taken = br_taken;

  load_use_interlock_unit #(.STALL_CYCLES(1), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  load_use_interlock_unit #(.STALL_CYCLES(3), .CNT_W(16)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
  load_use_interlock_unit #(.STALL_CYCLES(1), .CNT_W(2))  dut_c (.clk(clk), .reset(reset), .bus(if_c));

  // Observed {stall_pc, stall_if_of, bubble_ex, interlock_active} and count per DUT.
  logic [3:0]  obs_out [3];
  logic [15:0] obs_cnt [3];
  assign obs_out[0] = {if_a.stall_pc, if_a.stall_if_of, if_a.bubble_ex, if_a.interlock_active};
  assign obs_out[1] = {if_b.stall_pc, if_b.stall_if_of, if_b.bubble_ex, if_b.interlock_active};
  assign obs_out[2] = {if_c.stall_pc, if_c.stall_if_of, if_c.bubble_ex, if_c.interlock_active};
  assign obs_cnt[0] = if_a.interlock_count;
  assign obs_cnt[1] = if_b.interlock_count;
  assign obs_cnt[2] = {14'd0, if_c.interlock_count};

  // Reference model: cycles still owed to a stall, and event totals.
  int          stall_len [3] = '{1, 3, 1};
  int          cnt_max   [3] = '{65535, 65535, 3};
  int          owed      [3] = '{0, 0, 0};
  int          events    [3] = '{0, 0, 0};
  logic [3:0]  exp_out   [3];
  logic [15:0] exp_cnt   [3];

  int total = 0;
  int passed = 0;

  localparam logic [4:0] T_ADD = 5'b00000, T_MOV = 5'b01001, T_NOP = 5'b01101,
                         T_LD  = 5'b01110, T_ST  = 5'b01111, T_RET = 5'b10100;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic imm,
                                     input logic [3:0] rd, input logic [3:0] rs1,
                                     input logic [3:0] rs2);
    return {op, imm, rd, rs1, rs2, 14'd0};
  endfunction

  // Registers the OF instruction reads, matched against the ld destination.
  function automatic bit hazard_ref(input logic [31:0] of, input logic [31:0] ex);
    logic [4:0] eop, oop;
    logic [3:0] dst;
    bit         hit;
    eop = ex[31:27];
    dst = ex[25:22];
    oop = of[31:27];
    hit = 1'b0;
    if (eop != 5'b01110) return 1'b0;
    case (oop)
      5'b01101, 5'b10010, 5'b10000, 5'b10001, 5'b10011, 5'b01000, 5'b01001: ;
      5'b10100: hit = (dst == 4'hF);
      default:  hit = (of[21:18] == dst);
    endcase
    if (oop == 5'b01111)                  hit = hit | (of[25:22] == dst);
    else if (!of[26] && oop <= 5'd12)     hit = hit | (of[17:14] == dst);
    return hit;
  endfunction

  // Drives one cycle of stimulus, computes expected outputs for it, advances the model.
  task automatic drive_and_model(input logic [31:0] of, input logic [31:0] ex,
                                 input logic br, input logic rst);
    bit hz;
    @(negedge clk);
    of_ir = of; ex_ir = ex; br_taken = br; reset = rst;
    #2;
    hz = hazard_ref(of, ex);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        owed[k] = 0; events[k] = 0;
        exp_out[k] = 4'b0000; exp_cnt[k] = 16'd0;
      end else begin
        exp_cnt[k] = 16'(events[k]);
        if (br) begin
          exp_out[k] = 4'b0000; owed[k] = 0;
        end else if (owed[k] > 0) begin
          exp_out[k] = 4'b1111; owed[k]--;
        end else if (hz) begin
          exp_out[k] = 4'b1110; owed[k] = stall_len[k] - 1;
          if (events[k] < cnt_max[k]) events[k]++;
        end else begin
          exp_out[k] = 4'b0000;
        end
      end
    end
  endtask

  task automatic apply_reset();
    drive_and_model(mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0), 1'b0, 1'b1);
    drive_and_model(mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0), 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    drive_and_model(mk(T_ADD, 0, 4, 3, 2), mk(T_LD, 0, 3, 1, 0), 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_out[k] !== 4'b0000 || obs_cnt[k] !== 16'd0)
        $display("FAIL reset dut%0d: out=%b cnt=%0d, want out=0000 cnt=0", k, obs_out[k], obs_cnt[k]);
      else passed++;
    end
    apply_reset();
  endtask

  task automatic test_basic_stall();
    logic [31:0] seq_of [4];
    logic [31:0] seq_ex [4];
    apply_reset();
    seq_of = '{mk(T_ADD, 0, 4, 3, 2), mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0)};
    seq_ex = '{mk(T_LD, 0, 3, 1, 0),  mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0)};
    for (int c = 0; c < 4; c++) begin
      drive_and_model(seq_of[c], seq_ex[c], 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_out[k] !== exp_out[k] || obs_cnt[k] !== exp_cnt[k])
          $display("FAIL basic_stall c%0d dut%0d: out=%b cnt=%0d, want out=%b cnt=%0d",
                   c, k, obs_out[k], obs_cnt[k], exp_out[k], exp_cnt[k]);
        else passed++;
      end
    end
    total++;
    if (obs_cnt[0] !== 16'd1) $display("FAIL basic_count: cnt=%0d, want 1", obs_cnt[0]);
    else passed++;
  endtask

  task automatic test_no_false_hazard();
    apply_reset();
    // imm form: the rs2 field carries immediate bits that happen to equal r3
    drive_and_model(mk(T_ADD, 1, 4, 2, 3), mk(T_LD, 0, 3, 1, 0), 1'b0, 1'b0);
    total++;
    if (obs_out[0] !== 4'b0000) $display("FAIL no_false_add: out=%b, want 0000", obs_out[0]);
    else passed++;
    drive_and_model(mk(T_MOV, 1, 3, 3, 0), mk(T_LD, 0, 3, 1, 0), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_out[k] !== exp_out[k] || obs_cnt[k] !== exp_cnt[k])
        $display("FAIL no_false_mov dut%0d: out=%b cnt=%0d, want out=%b cnt=%0d",
                 k, obs_out[k], obs_cnt[k], exp_out[k], exp_cnt[k]);
      else passed++;
    end
    drive_and_model(mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0), 1'b0, 1'b0);
    total++;
    if (obs_cnt[0] !== 16'd0) $display("FAIL no_false_count: cnt=%0d, want 0", obs_cnt[0]);
    else passed++;
  endtask

  task automatic test_store_ret();
    apply_reset();
    drive_and_model(mk(T_ST, 0, 5, 2, 0), mk(T_LD, 0, 5, 1, 0), 1'b0, 1'b0);
    total++;
    if (obs_out[0] !== 4'b1110) $display("FAIL store_src: out=%b, want 1110", obs_out[0]);
    else passed++;
    for (int c = 0; c < 3; c++) drive_and_model(mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0), 1'b0, 1'b0);
    drive_and_model(mk(T_RET, 0, 0, 0, 0), mk(T_LD, 0, 15, 1, 0), 1'b0, 1'b0);
    total++;
    if (obs_out[0] !== 4'b1110) $display("FAIL ret_src: out=%b, want 1110", obs_out[0]);
    else passed++;
    drive_and_model(mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0), 1'b0, 1'b0);
    total++;
    if (obs_cnt[0] !== 16'd2) $display("FAIL store_ret_count: cnt=%0d, want 2", obs_cnt[0]);
    else passed++;
  endtask

  task automatic test_multi_cycle();
    logic [3:0] seq_stall, seq_act;
    apply_reset();
    seq_stall = '0; seq_act = '0;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive_and_model(mk(T_ADD, 0, 4, 3, 2), mk(T_LD, 0, 3, 1, 0), 1'b0, 1'b0);
      else        drive_and_model(mk(T_ADD, 0, 4, 3, 2), mk(T_NOP, 0, 0, 0, 0), 1'b0, 1'b0);
      seq_stall = {seq_stall[2:0], obs_out[1][3]};
      seq_act   = {seq_act[2:0], obs_out[1][0]};
    end
    total++;
    if (seq_stall !== 4'b1110 || seq_act !== 4'b0110)
      $display("FAIL multi_cycle: stall=%b act=%b, want stall=1110 act=0110", seq_stall, seq_act);
    else passed++;
    total++;
    if (obs_cnt[1] !== 16'd1) $display("FAIL multi_count: cnt=%0d, want 1", obs_cnt[1]);
    else passed++;
  endtask

  task automatic test_flush();
    apply_reset();
    drive_and_model(mk(T_ADD, 0, 4, 3, 2), mk(T_LD, 0, 3, 1, 0), 1'b0, 1'b0);
    drive_and_model(mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0), 1'b1, 1'b0);
    total++;
    if (obs_out[1] !== 4'b0000) $display("FAIL flush_cycle: out=%b, want 0000", obs_out[1]);
    else passed++;
    drive_and_model(mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0), 1'b0, 1'b0);
    total++;
    if (obs_out[1] !== 4'b0000 || obs_cnt[1] !== 16'd1)
      $display("FAIL flush_after: out=%b cnt=%0d, want out=0000 cnt=1", obs_out[1], obs_cnt[1]);
    else passed++;
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    drive_and_model(mk(T_ADD, 0, 4, 3, 2), mk(T_LD, 0, 3, 1, 0), 1'b0, 1'b0);
    @(posedge clk); #1;
    total++;
    if (obs_out[1] !== 4'b1111) $display("FAIL pre_reset_stall: out=%b, want 1111", obs_out[1]);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (obs_out[1] !== 4'b0000 || obs_cnt[1] !== 16'd0)
      $display("FAIL reset_mid_stall: out=%b cnt=%0d, want out=0000 cnt=0", obs_out[1], obs_cnt[1]);
    else passed++;
    apply_reset();
    drive_and_model(mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0), 1'b0, 1'b0);
    total++;
    if (obs_out[1] !== 4'b0000) $display("FAIL post_reset_run: out=%b, want 0000", obs_out[1]);
    else passed++;
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int e = 0; e < 5; e++) begin
      drive_and_model(mk(T_ADD, 0, 4, 3, 2), mk(T_LD, 0, 3, 1, 0), 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) drive_and_model(mk(T_NOP, 0, 0, 0, 0), mk(T_NOP, 0, 0, 0, 0), 1'b0, 1'b0);
    end
    total++;
    if (obs_cnt[2] !== 16'd3) $display("FAIL saturation: cnt=%0d, want 3", obs_cnt[2]);
    else passed++;
    total++;
    if (obs_cnt[0] !== 16'd5) $display("FAIL unsaturated: cnt=%0d, want 5", obs_cnt[0]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    // The same hazard held for 8 cycles: each stall end re-detects a fresh event.
    for (int c = 0; c < 8; c++) begin
      drive_and_model(mk(T_ADD, 0, 4, 3, 2), mk(T_LD, 0, 3, 1, 0), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_out[k] !== exp_out[k] || obs_cnt[k] !== exp_cnt[k])
          $display("FAIL back_to_back c%0d dut%0d: out=%b cnt=%0d, want out=%b cnt=%0d",
                   c, k, obs_out[k], obs_cnt[k], exp_out[k], exp_cnt[k]);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  regs [4] = '{4'd1, 4'd2, 4'd3, 4'd15};
    logic [31:0] of, ex;
    logic [4:0]  eop;
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      eop = ($urandom_range(0, 1) == 0) ? T_LD : 5'($urandom_range(0, 31));
      ex  = mk(eop, 1'($urandom), regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)]);
      of  = mk(5'($urandom_range(0, 20)), 1'($urandom), regs[$urandom_range(0, 3)],
               regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)]);
      drive_and_model(of, ex, ($urandom_range(0, 15) == 0), 1'b0);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_out[k] !== exp_out[k] || obs_cnt[k] !== exp_cnt[k])
          $display("FAIL random c%0d dut%0d: out=%b cnt=%0d, want out=%b cnt=%0d",
                   c, k, obs_out[k], obs_cnt[k], exp_out[k], exp_cnt[k]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_stall();
    test_no_false_hazard();
    test_store_ret();
    test_multi_cycle();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_use_interlock_unit.md
# load_use_interlock_unit

Detects load-use data hazards that forwarding cannot resolve. When the instruction in EX is `ld` and the instruction in OF reads its destination, the unit freezes PC and the IF/OF latch and injects a NOP bubble into the OF/EX latch. It also counts interlock events. It sits beside the src1/src2 forwarding units in the pipeline control path. The forwarding units flag resolvable conflicts; this block stalls the pipeline for the conflict they cannot resolve.

## Interface
- `STALL_CYCLES`, default 1: total stalled cycles per load-use event. Legal range is 1..15.
- `CNT_W`, default 16: width of the event counter.
- `clk` input 1: the single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `input_OF_IR` input 32: the instruction latched in IF/OF.
- `input_EX_IR` input 32: the instruction latched in OF/EX.
- `is_branch_taken` input 1: a branch resolved taken in EX this cycle.
- `stall_pc` output 1: hold PC.
- `stall_if_of` output 1: hold the IF/OF latch.
- `bubble_ex` output 1: load NOP (5'b01101) into OF/EX instead of the OF instruction.
- `interlock_active` output 1: the FSM is in STALL.
- `interlock_count` output CNT_W: saturating count of load-use events.

## Operation
- Instruction fields: opcode [31:27], imm [26], rd [25:22], rs1 [21:18], rs2 [17:14]. `ra` = 4'hF.
- EX writer condition: EX opcode is `ld` (01110). The EX destination is rd.
- OF src1 read:
  - rs1 is read unless the opcode is nop, b, beq, bgt, call, not or mov (01101, 10010, 10000, 10001, 10011, 01000, 01001).
  - `ret` (10100) reads `ra` as src1.
- OF src2 read:
  - rs2 is read when imm = 0 and the opcode is 00000–01100.
  - `st` (01111) reads rd as its store-data source.
- `hazard` = EX writer condition AND (src1 read with src1 == EX rd, OR src2/store-data read with that register == EX rd).
- FSM states are RUN and STALL. A down-counter `remain` is 4 bits wide.
- In RUN with `hazard`:
  - `stall_pc`, `stall_if_of` and `bubble_ex` are driven 1 combinationally in the same cycle (Mealy).
  - `remain` is loaded with STALL_CYCLES-1.
  - The FSM goes to STALL only if STALL_CYCLES > 1.
  - `interlock_count` increments by 1, saturating at all-ones.
- In STALL:
  - All three stall outputs are 1 and `interlock_active` is 1.
  - `remain` decrements each cycle. When `remain` == 1 in the current cycle, the next state is RUN.
  - `hazard` is ignored, because EX holds the bubble. The counter does not increment.
- Flush priority: `is_branch_taken` = 1 in any state forces all stall outputs to 0 that cycle, the next state to RUN, and `remain` to 0. The fetch unit flushes; a stall must never hold a wrong-path instruction.
- A hazard detected in the cycle immediately after STALL ends is a new event: it stalls and counts again.

## Timing
- Reset values: state RUN, `remain` 0, `interlock_count` 0. All outputs are 0 while `reset` is high, except that `hazard` combinational outputs are masked to 0 during reset.
- Reset asserted mid-STALL returns the FSM to RUN asynchronously. Stall outputs drop in the same cycle.
- Detection-to-stall latency is 0 cycles.
- Stall length per event is exactly STALL_CYCLES cycles. The OF instruction proceeds to EX in cycle STALL_CYCLES+1 after detection.
- `interlock_count` updates on the clock edge that ends the detection cycle.

## Structure
- Shared package `pipeline_pkg`:
  - opcode localparams (OP_LD, OP_ST, OP_NOP, OP_RET, OP_CALL, and so on),
  - field bit positions,
  - `RA_REG` = 4'hF,
  - state enum {RUN, STALL}.
- One sub-module, `operand_reads_decoder`: combinational. Given an IR, it outputs src1_used, src1, src2_used and src2. It is reusable by the forwarding units.

## Test plan
- Basic stall:
  - Stimulus: EX = `ld r3,[r1]`, OF = `add r4,r3,r2`, STALL_CYCLES = 1.
  - Required: stall_pc, stall_if_of and bubble_ex are 1 for one cycle; count goes 0→1; no STALL state.
- No false hazard:
  - Stimulus: EX = `ld r3`, OF = `add r4,r2,#5` with imm = 1 and rs1 = r2; then OF = `mov r3,#1`.
  - Required: no stall and count stays 0.
- Store and ret sources:
  - Stimulus: EX = `ld r5`, OF = `st r5,[r2]`. Separately, EX = `ld r15`, OF = `ret`.
  - Required: each case stalls and the count reaches 2.
- Multi-cycle stall:
  - Stimulus: STALL_CYCLES = 3 and a hazard.
  - Required: stall outputs are 1 for exactly 3 cycles; interlock_active is 1 in cycles 2–3; count is +1 only.
- Flush priority:
  - Stimulus: is_branch_taken = 1 in the second cycle of a 3-cycle stall.
  - Required: outputs are 0 that cycle, the next state is RUN, and the count is unchanged.
- Reset and saturation:
  - Stimulus: reset pulse mid-STALL.
  - Required: immediate RUN with outputs 0.
  - Stimulus: with CNT_W = 2, apply 5 events.
  - Required: count saturates at 3.
